bp_update_scheduler: RTL and testbench

// - Sequences the branch predictor's single update port.
// - Arbitrates resolved-branch updates from two execute-stage requesters with round-robin and buffers them in a small FIFO.
// - Drains the FIFO one update per cycle into the predictor.
// - Runs the table-initialisation sweep after reset and after a pipeline flush request.
// - Sits between the branch-resolution units and hybrid_predictor (update_en/update_pc/actual_taken side).

---
 rtl/bp_pkg.sv | 16 +
 rtl/bp_upd_fifo.sv | 59 +++++
 rtl/bp_update_scheduler.sv | 125 ++++++++++++
 tb/tb_bp_update_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor update scheduler.
// The update record is {pc, taken}; the scheduler runs INIT (table sweep) or RUN.
package bp_pkg;
   localparam int BP_IDX_W = 10;
   localparam int BP_PC_W  = 32;

   typedef struct packed {
      logic [BP_PC_W-1:0] pc;
      logic               taken;
   } upd_rec_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_e;
endpackage

// File: rtl/bp_upd_fifo.sv
// Small registered FIFO for pending predictor updates; no same-cycle passthrough.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bp_upd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];

   // clear wins over push/pop so a flush discards whatever moved this cycle
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q[AW-1:0]] = din;
         wr_d                = wr_q + PTR_ONE;
      end
      if (pop) begin
         rd_d = rd_q + PTR_ONE;
      end
      if (clear) begin
         wr_d = '0;
         rd_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   assign empty = (wr_q == rd_q);
   assign dout  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/bp_update_scheduler.sv
// Sequences the predictor's single update port: post-reset/flush table sweep,
// then round-robin arbitration of two requesters into a FIFO drained one per cycle.
module bp_update_scheduler
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = BP_IDX_W,
   parameter int PC_W  = BP_PC_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [PC_W-1:0]  req0_pc,
   input  logic             req0_taken,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [PC_W-1:0]  req1_pc,
   input  logic             req1_taken,
   output logic             req1_ready,
   input  logic             flush_req,
   input  logic             upd_stall,
   output logic             update_en,
   output logic [PC_W-1:0]  update_pc,
   output logic             actual_taken,
   output logic             init_en,
   output logic [IDX_W-1:0] init_idx,
   output logic             init_busy
);
   localparam int REC_W = PC_W + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = '1;
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   bp_state_e        state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             rr_q, rr_d;
   logic             run, push, pop, clear;
   logic             grant_valid, grant_sel;
   logic             fifo_full, fifo_empty;
   logic [REC_W-1:0] push_rec, head_rec;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (flush_req) begin
               cnt_d = '0;
            end else if (cnt_q == IDX_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_ONE;
            end
         end
         ST_RUN: begin
            if (flush_req) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // rr names the preferred requester on a tie; it points away from the last winner
   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid = 1'b1;
         grant_sel   = rr_q;
      end else if (req0_valid) begin
         grant_valid = 1'b1;
      end else if (req1_valid) begin
         grant_valid = 1'b1;
         grant_sel   = 1'b1;
      end
   end

   // Outputs are gated with reset so they hold safe values even mid-drain
   always_comb begin
      run        = (state_q == ST_RUN) && !reset;
      push       = run && grant_valid && !fifo_full;
      pop        = run && !fifo_empty && !upd_stall;
      clear      = run && flush_req;
      req0_ready = push && !grant_sel;
      req1_ready = push && grant_sel;
      update_en  = pop;
      init_en    = (state_q == ST_INIT) && !reset;
      init_busy  = (state_q == ST_INIT) || reset;
      init_idx   = cnt_q;
      rr_d       = push ? !grant_sel : rr_q;
      push_rec   = grant_sel ? {req1_pc, req1_taken} : {req0_pc, req0_taken};
   end

   assign update_pc    = head_rec[REC_W-1:1];
   assign actual_taken = head_rec[0];

   bp_upd_fifo #(
      .DEPTH (DEPTH),
      .W     (REC_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .din   (push_rec),
      .dout  (head_rec),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Randomized and directed bench for bp_update_scheduler against a queue-based model.
module tb_bp_update_scheduler;
   localparam int DEPTH = 4;
   localparam int IDX_W = 10;
   localparam int PC_W  = 32;
   localparam int SWEEP = 1 << IDX_W;

   logic             clk;
   logic             reset;
   logic             req0_valid, req1_valid;
   logic [PC_W-1:0]  req0_pc, req1_pc;
   logic             req0_taken, req1_taken;
   logic             req0_ready, req1_ready;
   logic             flush_req, upd_stall;
   logic             update_en;
   logic [PC_W-1:0]  update_pc;
   logic             actual_taken;
   logic             init_en;
   logic [IDX_W-1:0] init_idx;
   logic             init_busy;

   // Reference model: sweep position, pending updates in order, tie preference
   logic [PC_W:0] exp_q[$];
   bit            m_init;
   int            m_idx;
   bit            m_rr;

   int n_asserts;
   int n_fail;
   int init_cnt;
   int upd_cnt;

   bp_update_scheduler #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .PC_W  (PC_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_pc      (req0_pc),
      .req0_taken   (req0_taken),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_pc      (req1_pc),
      .req1_taken   (req1_taken),
      .req1_ready   (req1_ready),
      .flush_req    (flush_req),
      .upd_stall    (upd_stall),
      .update_en    (update_en),
      .update_pc    (update_pc),
      .actual_taken (actual_taken),
      .init_en      (init_en),
      .init_idx     (init_idx),
      .init_busy    (init_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check combinational outputs, advance model
   task automatic step(input logic r, input logic v0, input logic [PC_W-1:0] p0, input logic t0,
                       input logic v1, input logic [PC_W-1:0] p1, input logic t1,
                       input logic fl, input logic st);
      logic e_busy, e_init, e_r0, e_r1, e_upd, full;
      int   g;
      @(negedge clk);
      reset      = r;
      req0_valid = v0;
      req0_pc    = p0;
      req0_taken = t0;
      req1_valid = v1;
      req1_pc    = p1;
      req1_taken = t1;
      flush_req  = fl;
      upd_stall  = st;
      #1;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      e_upd = 1'b0;
      if (r) begin
         e_busy = 1'b1;
         e_init = 1'b0;
      end else if (m_init) begin
         e_busy = 1'b1;
         e_init = 1'b1;
      end else begin
         e_busy = 1'b0;
         e_init = 1'b0;
         full   = (exp_q.size() == DEPTH);
         g = -1;
         if (v0 && v1)  g = m_rr ? 1 : 0;
         else if (v0)   g = 0;
         else if (v1)   g = 1;
         e_r0  = (g == 0) && !full;
         e_r1  = (g == 1) && !full;
         e_upd = (exp_q.size() != 0) && !st;
      end
      check("init_busy", init_busy, e_busy);
      check("init_en", init_en, e_init);
      check("req0_ready", req0_ready, e_r0);
      check("req1_ready", req1_ready, e_r1);
      check("update_en", update_en, e_upd);
      if (!r && m_init) check("init_idx", init_idx, m_idx);
      if (!r && !m_init && exp_q.size() != 0) check("head_rec", {update_pc, actual_taken}, exp_q[0]);
      if (init_en) init_cnt++;
      if (update_en) upd_cnt++;

      if (r) begin
         m_init = 1'b1;
         m_idx  = 0;
         m_rr   = 1'b0;
         exp_q.delete();
      end else if (m_init) begin
         if (fl) m_idx = 0;
         else if (m_idx == SWEEP - 1) begin
            m_init = 1'b0;
            m_idx  = 0;
         end else m_idx++;
      end else begin
         if (e_upd) void'(exp_q.pop_front());
         if (e_r0 || e_r1) begin
            exp_q.push_back(e_r0 ? {p0, t0} : {p1, t1});
            m_rr = e_r0;
         end
         if (fl) begin
            exp_q.delete();
            m_init = 1'b1;
            m_idx  = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic req0_only(input int n, input logic st);
      for (int i = 0; i < n; i++) step(0, 1, $urandom, $urandom_range(0, 1), 0, '0, 0, 0, st);
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      m_init    = 1'b1;
      m_idx     = 0;
      m_rr      = 1'b0;
      reset      = 1'b1;
      req0_valid = 1'b0;
      req0_pc    = '0;
      req0_taken = 1'b0;
      req1_valid = 1'b0;
      req1_pc    = '0;
      req1_taken = 1'b0;
      flush_req  = 1'b0;
      upd_stall  = 1'b0;

      step(1, 0, '0, 0, 0, '0, 0, 0, 0);
      step(1, 1, 32'h10, 1, 1, 32'h20, 0, 0, 0);
      init_cnt = 0;
      idle(SWEEP);
      check("sweep_len", init_cnt, SWEEP);
      idle(2);

      // Both requesters every cycle: alternating grants, one update per cycle
      upd_cnt = 0;
      for (int i = 0; i < 12; i++) step(0, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0);
      check("throughput", upd_cnt, 11);
      idle(3);

      // Stall fills the FIFO, then release while full and still requesting
      req0_only(10, 1);
      req0_only(6, 0);
      idle(6);

      // Flush with three queued entries
      req0_only(3, 1);
      step(0, 0, '0, 0, 0, '0, 0, 1, 1);
      init_cnt = 0;
      idle(SWEEP);
      check("flush_sweep_len", init_cnt, SWEEP);
      idle(2);

      // Reset at sweep index 500
      step(0, 0, '0, 0, 0, '0, 0, 1, 0);
      idle(500);
      for (int i = 0; i < 3; i++) step(1, 1, $urandom, 1, 1, $urandom, 0, 0, 1);
      init_cnt = 0;
      idle(SWEEP);
      check("reset_sweep_len", init_cnt, SWEEP);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 599) == 0,
              $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1),
              $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1),
              $urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
